// File: rtl/pwm_multichannel.sv
// Multi-channel PWM driven from one shared counter with a clock prescaler and edge/center modes.
// Duty writes land in a pending shadow register and reach the comparator only at a period boundary.
module pwm_multichannel #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                mode,
    input  logic [2:0]          prescale,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_duty,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic                dir_down_q, dir_down_d;
    logic [6:0]          div_q, div_d;
    logic [6:0]          div_top;
    logic                mode_q, mode_d;
    logic [2:0]          prescale_q, prescale_d;
    logic                tick;
    logic                boundary;
    logic                reload;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                period_start_q;

    assign div_top = 7'((8'd1 << prescale_q) - 8'd1);
    assign tick    = enable && (div_q == div_top);

    always_comb begin
        div_d      = div_q;
        cnt_d      = cnt_q;
        dir_down_d = dir_down_q;
        if (!enable) begin
            div_d      = '0;
            cnt_d      = '0;
            dir_down_d = 1'b0;
        end else begin
            div_d = tick ? 7'd0 : div_q + 7'd1;
            if (tick) begin
                if (!mode_q) begin
                    cnt_d = cnt_q + WIDTH'(1);
                end else if (!dir_down_q) begin
                    if (cnt_q == MAX) begin
                        cnt_d      = cnt_q - WIDTH'(1);
                        dir_down_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end
        // Every period restarts counting upwards, whichever mode comes next.
        if (boundary) begin
            dir_down_d = 1'b0;
        end
    end

    assign boundary = tick && (cnt_d == '0);
    // While disabled the latched settings track their sources so a restart uses the latest values.
    assign reload   = !enable || boundary;

    assign mode_d     = reload ? mode : mode_q;
    assign prescale_d = reload ? prescale : prescale_q;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] pending_q, pending_d;
            logic [WIDTH-1:0] active_q, active_d;

            // Out-of-range channel indices never match any gi, so those writes are dropped.
            assign pending_d = (wr_en && (wr_ch == CH_W'(gi))) ? wr_duty : pending_q;
            assign active_d  = reload ? pending_d : active_q;
            assign pwm_d[gi] = enable && (cnt_q < active_q);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pending_q <= '0;
                    active_q  <= '0;
                end else begin
                    pending_q <= pending_d;
                    active_q  <= active_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            dir_down_q     <= 1'b0;
            div_q          <= '0;
            mode_q         <= 1'b0;
            prescale_q     <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            dir_down_q     <= dir_down_d;
            div_q          <= div_d;
            mode_q         <= mode_d;
            prescale_q     <= prescale_d;
            pwm_q          <= pwm_d;
            period_start_q <= boundary;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench for pwm_multichannel (WIDTH=4, CHANNELS=3) against a period-position model.
module tb_pwm_multichannel;

    localparam int W    = 4;
    localparam int CH   = 3;
    localparam int CHW  = 2;
    localparam int MAXV = (1 << W) - 1;

    logic           clk;
    logic           rst_n;
    logic           enable;
    logic           mode;
    logic [2:0]     prescale;
    logic           wr_en;
    logic [CHW-1:0] wr_ch;
    logic [W-1:0]   wr_duty;
    logic [CH-1:0]  pwm_out;
    logic           period_start;

    pwm_multichannel #(
        .WIDTH    (W),
        .CHANNELS (CH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .mode         (mode),
        .prescale     (prescale),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_duty      (wr_duty),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: position within the period in ticks, clks elapsed within the current tick.
    int            m_tick_clks;
    int            m_pos;
    int            m_mode;
    int            m_ps;
    int            m_pend[CH];
    int            m_act[CH];
    logic [CH-1:0] exp_pwm;
    logic          exp_ps;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int cnt_at(input int pos, input int md);
        if (md == 0 || pos <= MAXV) return pos;
        return 2 * MAXV - pos;
    endfunction

    function automatic int period_ticks(input int md);
        return (md != 0) ? 2 * MAXV : MAXV + 1;
    endfunction

    task automatic model_reset();
        m_tick_clks = 0;
        m_pos       = 0;
        m_mode      = 0;
        m_ps        = 0;
        for (int i = 0; i < CH; i++) begin
            m_pend[i] = 0;
            m_act[i]  = 0;
        end
        exp_pwm = '0;
        exp_ps  = 1'b0;
    endtask

    task automatic model_step();
        int pend_new[CH];
        for (int i = 0; i < CH; i++) pend_new[i] = m_pend[i];
        if (wr_en && (int'(wr_ch) < CH)) pend_new[wr_ch] = int'(wr_duty);
        if (!enable) begin
            exp_pwm     = '0;
            exp_ps      = 1'b0;
            m_tick_clks = 0;
            m_pos       = 0;
            m_mode      = int'(mode);
            m_ps        = int'(prescale);
            for (int i = 0; i < CH; i++) m_act[i] = pend_new[i];
        end else begin
            for (int i = 0; i < CH; i++) exp_pwm[i] = (cnt_at(m_pos, m_mode) < m_act[i]);
            exp_ps = 1'b0;
            m_tick_clks++;
            if (m_tick_clks == (1 << m_ps)) begin
                m_tick_clks = 0;
                m_pos++;
                if (m_pos == period_ticks(m_mode)) begin
                    m_pos  = 0;
                    exp_ps = 1'b1;
                    m_mode = int'(mode);
                    m_ps   = int'(prescale);
                    for (int i = 0; i < CH; i++) m_act[i] = pend_new[i];
                end
            end
        end
        for (int i = 0; i < CH; i++) m_pend[i] = pend_new[i];
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
        check_val("pwm_out", 32'(pwm_out), 32'(exp_pwm));
        check_val("period_start", 32'(period_start), 32'(exp_ps));
    endtask

    task automatic write_duty(input int ch, input int d);
        wr_en   = 1'b1;
        wr_ch   = CHW'(ch);
        wr_duty = W'(d);
        cycle();
        wr_en   = 1'b0;
    endtask

    task automatic wait_ps(input int budget, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!period_start && n < budget);
        if (!period_start) check_val("period_start_timeout", 32'(n), 32'(budget + 1));
    endtask

    task automatic count_high(input int ch, input int n, output int hi);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            cycle();
            hi += int'(pwm_out[ch]);
        end
    endtask

    initial begin
        int n;
        int hi;

        rst_n    = 1'b0;
        enable   = 1'b0;
        mode     = 1'b0;
        prescale = 3'd0;
        wr_en    = 1'b0;
        wr_ch    = '0;
        wr_duty  = '0;
        model_reset();

        #1;
        check_val("reset_pwm", 32'(pwm_out), 32'd0);
        check_val("reset_ps", 32'(period_start), 32'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
        $display("phase reset done");

        // Edge mode, duty written while disabled.
        write_duty(0, 5);
        cycle();
        enable = 1'b1;
        wait_ps(40, n);
        check_val("restart_first_period", 32'(n), 32'd16);
        count_high(0, 16, hi);
        check_val("edge_d5_high", 32'(hi), 32'd5);
        check_val("edge_period16", 32'(period_start), 32'd1);
        $display("phase edge duty=5 high=%0d", hi);

        // Center mode.
        mode = 1'b1;
        write_duty(1, 5);
        wait_ps(40, n);
        count_high(1, 30, hi);
        check_val("center_d5_high", 32'(hi), 32'd9);
        check_val("center_period30", 32'(period_start), 32'd1);
        write_duty(1, 15);
        wait_ps(40, n);
        count_high(1, 30, hi);
        check_val("center_d15_high", 32'(hi), 32'd29);
        write_duty(1, 0);
        wait_ps(40, n);
        count_high(1, 30, hi);
        check_val("center_d0_high", 32'(hi), 32'd0);
        $display("phase center done");

        // Mid-period and boundary-coincident writes.
        mode = 1'b0;
        write_duty(2, 3);
        wait_ps(40, n);
        hi = 0;
        for (int k = 0; k < 16; k++) begin
            wr_en   = (k == 3);
            wr_ch   = 2'd2;
            wr_duty = 4'd12;
            cycle();
            hi += int'(pwm_out[2]);
        end
        wr_en = 1'b0;
        check_val("midwrite_old_duty", 32'(hi), 32'd3);
        check_val("midwrite_boundary", 32'(period_start), 32'd1);
        hi = 0;
        for (int k = 0; k < 16; k++) begin
            wr_en   = (k == 15);
            wr_ch   = 2'd2;
            wr_duty = 4'd7;
            cycle();
            hi += int'(pwm_out[2]);
        end
        wr_en = 1'b0;
        check_val("midwrite_new_duty", 32'(hi), 32'd12);
        check_val("coincident_boundary", 32'(period_start), 32'd1);
        count_high(2, 16, hi);
        check_val("coincident_write_applied", 32'(hi), 32'd7);
        $display("phase writes done");

        // Prescaler.
        write_duty(0, 8);
        prescale = 3'd2;
        wait_ps(100, n);
        count_high(0, 64, hi);
        check_val("prescale2_high", 32'(hi), 32'd32);
        check_val("prescale2_period64", 32'(period_start), 32'd1);
        for (int k = 0; k < 10; k++) cycle();
        prescale = 3'd0;
        wait_ps(100, n);
        check_val("prescale_change_deferred", 32'(n), 32'd54);
        wait_ps(100, n);
        check_val("prescale0_period16", 32'(n), 32'd16);
        $display("phase prescale done");

        // Disable mid-period, then restart.
        for (int k = 0; k < 3; k++) cycle();
        enable = 1'b0;
        cycle();
        check_val("disable_low", 32'(pwm_out), 32'd0);
        for (int k = 0; k < 4; k++) cycle();
        enable = 1'b1;
        wait_ps(40, n);
        check_val("reenable_period", 32'(n), 32'd16);
        $display("phase enable done");

        // Out-of-range channel write leaves all channels unchanged (0:8, 1:0, 2:7).
        write_duty(3, 9);
        wait_ps(40, n);
        count_high(0, 16, hi);
        check_val("oor_ch0", 32'(hi), 32'd8);
        count_high(1, 16, hi);
        check_val("oor_ch1", 32'(hi), 32'd0);
        count_high(2, 16, hi);
        check_val("oor_ch2", 32'(hi), 32'd7);
        $display("phase out-of-range done");

        // Randomized traffic against the model.
        for (int k = 0; k < 2500; k++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_ch   = CHW'($urandom_range(0, 3));
            wr_duty = W'($urandom_range(0, MAXV));
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            if ($urandom_range(0, 59) == 0) prescale = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            cycle();
        end
        wr_en = 1'b0;
        $display("phase random done");

        // Async reset mid-period with outputs high.
        enable   = 1'b1;
        mode     = 1'b0;
        prescale = 3'd0;
        for (int i = 0; i < CH; i++) write_duty(i, 15);
        wait_ps(400, n);
        wait_ps(40, n);
        cycle();
        cycle();
        check_val("pre_reset_high", 32'(pwm_out), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_reset_pwm", 32'(pwm_out), 32'd0);
        check_val("async_reset_ps", 32'(period_start), 32'd0);
        model_reset();
        cycle();
        rst_n = 1'b1;
        hi = 0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            hi += int'(pwm_out != '0);
        end
        check_val("post_reset_low", 32'(hi), 32'd0);
        $display("phase async reset done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
